// File: rtl/rida_isa_pkg.sv
// rida_isa_pkg: RIDA instruction field layout, type/opcode constants, loader states and error codes
package rida_isa_pkg;
  localparam int COND_LSB   = 30;
  localparam int TIPO_LSB   = 28;
  localparam int OPC_LSB    = 25;
  localparam int RD_LSB     = 21;
  localparam int RN_LSB     = 17;
  localparam int SHIFT_LSB  = 15;
  localparam int MEMIDX_BIT = 14;
  localparam int OP2_LSB    = 0;
  typedef enum logic [1:0] {TIPO_REG = 2'b00, TIPO_IMM = 2'b01, TIPO_MEM = 2'b10, TIPO_CTRL = 2'b11} tipo_e;
  localparam logic [2:0] OPC_MOV      = 3'b011;
  localparam logic [2:0] IMM_OPC_MAX  = 3'b101;
  localparam logic [2:0] CTRL_OPC_MAX = 3'b010;
  localparam logic [1:0] SHIFT_RSVD   = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FINISH, ST_RUN, ST_ERROR} state_e;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
endpackage

// File: rtl/rida_instr_pack.sv
// rida_instr_pack: combinational packer of decoded RIDA fields into a 32-bit word plus legality check
module rida_instr_pack
  import rida_isa_pkg::*;
(
  input  logic [1:0]  cond,
  input  logic [1:0]  tipo,
  input  logic [2:0]  opcode,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic [1:0]  shift,
  input  logic        memidx,
  input  logic [13:0] op2,
  output logic [31:0] word,
  output logic        legal
);
  logic shift_bad;
  assign word = (32'(cond) << COND_LSB) | (32'(tipo) << TIPO_LSB) | (32'(opcode) << OPC_LSB)
              | (32'(rd) << RD_LSB) | (32'(rn) << RN_LSB) | (32'(shift) << SHIFT_LSB)
              | (32'(memidx) << MEMIDX_BIT) | (32'(op2) << OP2_LSB);
  // only MOV may carry a shift flag
  assign shift_bad = shift != 2'b00 && opcode != OPC_MOV;
  always_comb
    legal = tipo_e'(tipo) == TIPO_REG ? !(shift_bad || shift == SHIFT_RSVD) :
            tipo_e'(tipo) == TIPO_IMM ? !shift_bad && opcode <= IMM_OPC_MAX :
            tipo_e'(tipo) == TIPO_MEM ? !opcode[2] :
                                        opcode <= CTRL_OPC_MAX;
endmodule

// File: rtl/rida_instr_loader.sv
// rida_instr_loader: streams packed instructions into instruction memory and holds the CPU
// in reset until the whole program is written
module rida_instr_loader
  import rida_isa_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_cond,
  input  logic [1:0]        in_tipo,
  input  logic [2:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [1:0]        in_shift,
  input  logic              in_memidx,
  input  logic [13:0]       in_op2,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CW-1:0]     words_loaded
);
  state_e      state;
  logic [31:0] word;
  logic        legal;
  logic        full;
  logic        take;
  rida_instr_pack u_pack (
    .cond   (in_cond),
    .tipo   (in_tipo),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rn     (in_rn),
    .shift  (in_shift),
    .memidx (in_memidx),
    .op2    (in_op2),
    .word   (word),
    .legal  (legal)
  );
  assign full = words_loaded == CW'(DEPTH);
  assign take = in_valid && in_ready;
  // in_ready is a registered copy of (state == ST_LOAD)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_LOAD:
          if (take) begin
            if (full || !legal) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= full ? ERR_OVERFLOW : ERR_ILLEGAL;
            end else begin
              imem_we      <= 1'b1;
              imem_addr    <= ADDR_W'(words_loaded) << 2;
              imem_wdata   <= word;
              words_loaded <= words_loaded + CW'(1);
              if (in_last) begin
                state    <= ST_FINISH;
                in_ready <= 1'b0;
              end
            end
          end
        ST_FINISH: begin
          state   <= ST_RUN;
          busy    <= 1'b0;
          done    <= 1'b1;
          cpu_rst <= 1'b1;
        end
        default:
          if (start) begin
            state        <= ST_LOAD;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            cpu_rst      <= 1'b0;
            words_loaded <= '0;
            imem_addr    <= '0;
          end
      endcase
    end
endmodule
